// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the two-requester data memory arbiter.
//   DM_SIZE_DEFAULT : default data memory size in bytes
//   state_t         : arbiter FSM state (IDLE accepts requests, RDATA returns read data)
//   req_id_t        : requester identifier, 0 = r0, 1 = r1
package dmem_arb_pkg;

  localparam int DM_SIZE_DEFAULT = 1024;

  typedef enum logic {
    IDLE  = 1'b0,
    RDATA = 1'b1
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant logic with its own last-grant pointer.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   enable_i       : grants may only be issued while high
//   req_i[1:0]     : request vector, bit K for requester K
//   gnt_o[1:0]     : one-hot grant, combinational from req_i
//   winner_o       : ID of the selected requester (valid while any gnt_o bit is set)
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output req_id_t    winner_o
);

  req_id_t lastGnt_q;
  req_id_t lastGnt_d;

  // Pick the winner: on contention the requester that was not granted last
  // wins; a lone requester always wins. The pointer follows every grant.
  always_comb begin
    gnt_o     = 2'b00;
    lastGnt_d = lastGnt_q;
    if (req_i == 2'b11) begin
      winner_o = ~lastGnt_q;
    end else begin
      winner_o = req_i[1];
    end
    if (enable_i && (req_i != 2'b00)) begin
      gnt_o     = winner_o ? 2'b10 : 2'b01;
      lastGnt_d = winner_o;
    end
  end

  // Reset points at r1 as last-granted so r0 wins the first contention.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lastGnt_q <= 1'b1;
    end else begin
      lastGnt_q <= lastGnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto a single synchronous data memory port.
// Ports:
//   clock, reset_n                 : clock and asynchronous active-low reset
//   rK_req/we/addr/wdata (K=0,1)   : request held until granted
//   rK_gnt, rK_err                 : grant pulse, error pulse on illegal request
//   rK_rvalid, rK_rdata            : read data return, one cycle after grant
//   mem_read, mem_write            : memory strobes, only in the grant cycle
//   mem_addr, mem_wdata            : memory address/data, zero when idle
//   mem_rdata                      : registered memory output
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DM_SIZE = DM_SIZE_DEFAULT,
  parameter int ADDR_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [31:0]       r0_wdata,
  output logic              r0_gnt,
  output logic              r0_err,
  output logic              r0_rvalid,
  output logic [31:0]       r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [31:0]       r1_wdata,
  output logic              r1_gnt,
  output logic              r1_err,
  output logic              r1_rvalid,
  output logic [31:0]       r1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t  state_q, state_d;
  req_id_t rdId_q, rdId_d;

  logic [1:0]        gnt;
  req_id_t           winner;
  logic              arbEnable;
  logic              selWe;
  logic [ADDR_W-1:0] selAddr;
  logic [31:0]       selWdata;
  logic [ADDR_W:0]   lastByte;
  logic              legal;
  logic              anyGnt;

  // Gating with reset_n keeps grants and strobes low for the whole reset pulse.
  assign arbEnable = reset_n && (state_q == IDLE);

  rr_arbiter2 u_rr (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable_i (arbEnable),
    .req_i    ({r1_req, r0_req}),
    .gnt_o    (gnt),
    .winner_o (winner)
  );

  assign anyGnt   = |gnt;
  assign selWe    = winner ? r1_we    : r0_we;
  assign selAddr  = winner ? r1_addr  : r0_addr;
  assign selWdata = winner ? r1_wdata : r0_wdata;

  // One extra bit so addr+3 cannot wrap past the top of the address space.
  assign lastByte = {1'b0, selAddr} + (ADDR_W+1)'(3);
  assign legal    = (selAddr[1:0] == 2'b00) && (lastByte < (ADDR_W+1)'(DM_SIZE));

  // Grant, error and memory-side outputs for the current cycle.
  always_comb begin
    r0_gnt    = gnt[0];
    r1_gnt    = gnt[1];
    r0_err    = gnt[0] & ~legal;
    r1_err    = gnt[1] & ~legal;
    mem_read  = anyGnt & legal & ~selWe;
    mem_write = anyGnt & legal & selWe;
    mem_addr  = (mem_read || mem_write) ? selAddr : '0;
    mem_wdata = mem_write ? selWdata : '0;
  end

  // Read data returns to whichever requester owned the outstanding read.
  always_comb begin
    r0_rvalid = (state_q == RDATA) && (rdId_q == 1'b0);
    r1_rvalid = (state_q == RDATA) && (rdId_q == 1'b1);
    r0_rdata  = r0_rvalid ? mem_rdata : 32'h0;
    r1_rdata  = r1_rvalid ? mem_rdata : 32'h0;
  end

  // Only a legal read leaves IDLE; RDATA always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    rdId_d  = rdId_q;
    unique case (state_q)
      IDLE: begin
        if (mem_read) begin
          state_d = RDATA;
          rdId_d  = winner;
        end
      end
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rdId_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rdId_q  <= rdId_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a simple synchronous
// memory model attached to the mem_* port.
module tb_dmem_arbiter;

  logic        clock;
  logic        reset_n;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic        r0_gnt, r0_err, r0_rvalid, r1_gnt, r1_err, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] memModel [0:255];

  typedef struct {
    logic        r0Req;
    logic        r0We;
    logic [31:0] r0Addr;
    logic [31:0] r0Wdata;
    logic        r1Req;
    logic        r1We;
    logic [31:0] r1Addr;
    logic [31:0] r1Wdata;
    logic [1:0]  expGnt;
    logic [1:0]  expErr;
    logic [1:0]  expRvalid;
    logic [31:0] expRdata0;
    logic [31:0] expRdata1;
    logic        expRead;
    logic        expWrite;
    logic [31:0] expAddr;
    logic [31:0] expWdata;
  } vecT;

  vecT vecs[$];
  int  testsRun    = 0;
  int  testsFailed = 0;

  dmem_arbiter #(.DM_SIZE(1024), .ADDR_W(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_gnt    (r0_gnt),
    .r0_err    (r0_err),
    .r0_rvalid (r0_rvalid),
    .r0_rdata  (r0_rdata),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_gnt    (r1_gnt),
    .r1_err    (r1_err),
    .r1_rvalid (r1_rvalid),
    .r1_rdata  (r1_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous memory: write on strobe, registered read output.
  always @(posedge clock) begin
    if (mem_write) memModel[mem_addr[9:2]] <= mem_wdata;
    if (mem_read)  mem_rdata <= memModel[mem_addr[9:2]];
  end

  function automatic vecT mkVec(
    input logic r0Req, input logic r0We, input logic [31:0] r0Addr, input logic [31:0] r0Wdata,
    input logic r1Req, input logic r1We, input logic [31:0] r1Addr, input logic [31:0] r1Wdata,
    input logic [1:0] expGnt, input logic [1:0] expErr, input logic [1:0] expRvalid,
    input logic [31:0] expRdata0, input logic [31:0] expRdata1,
    input logic expRead, input logic expWrite, input logic [31:0] expAddr, input logic [31:0] expWdata);
    vecT v;
    v.r0Req = r0Req;   v.r0We = r0We;   v.r0Addr = r0Addr;   v.r0Wdata = r0Wdata;
    v.r1Req = r1Req;   v.r1We = r1We;   v.r1Addr = r1Addr;   v.r1Wdata = r1Wdata;
    v.expGnt = expGnt; v.expErr = expErr; v.expRvalid = expRvalid;
    v.expRdata0 = expRdata0; v.expRdata1 = expRdata1;
    v.expRead = expRead; v.expWrite = expWrite; v.expAddr = expAddr; v.expWdata = expWdata;
    return v;
  endfunction

  task automatic applyStimulus(input vecT v);
    r0_req = v.r0Req; r0_we = v.r0We; r0_addr = v.r0Addr; r0_wdata = v.r0Wdata;
    r1_req = v.r1Req; r1_we = v.r1We; r1_addr = v.r1Addr; r1_wdata = v.r1Wdata;
  endtask

  task automatic checkOutput(input string name, input vecT v);
    logic [1:0] gotGnt, gotErr, gotRv;
    gotGnt = {r1_gnt, r0_gnt};
    gotErr = {r1_err, r0_err};
    gotRv  = {r1_rvalid, r0_rvalid};
    testsRun++;
    if (gotGnt !== v.expGnt || gotErr !== v.expErr || gotRv !== v.expRvalid ||
        r0_rdata !== v.expRdata0 || r1_rdata !== v.expRdata1 ||
        mem_read !== v.expRead || mem_write !== v.expWrite ||
        mem_addr !== v.expAddr || mem_wdata !== v.expWdata) begin
      testsFailed++;
      $display("[TB] FAIL %s: got gnt=%b err=%b rv=%b rd0=%h rd1=%h mr=%b mw=%b ma=%h mwd=%h; expected gnt=%b err=%b rv=%b rd0=%h rd1=%h mr=%b mw=%b ma=%h mwd=%h",
               name, gotGnt, gotErr, gotRv, r0_rdata, r1_rdata, mem_read, mem_write, mem_addr, mem_wdata,
               v.expGnt, v.expErr, v.expRvalid, v.expRdata0, v.expRdata1, v.expRead, v.expWrite, v.expAddr, v.expWdata);
    end
  endtask

  task automatic checkWord(input string name, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  initial begin
    vecT v;
    for (int i = 0; i < 256; i++) memModel[i] = 32'hC0DE_0000 | i;
    mem_rdata = 32'h0;
    reset_n   = 1'b1;
    applyStimulus(mkVec(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0,
                        2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0));
    #2 reset_n = 1'b0;

    // Both requesters read every cycle from reset: r0, r1, r0 two cycles apart
    vecs.push_back(mkVec(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h24,32'h0, 2'b01,2'b00,2'b00,32'h0,32'h0, 1'b1,1'b0,32'h20,32'h0));
    vecs.push_back(mkVec(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h24,32'h0, 2'b00,2'b00,2'b01,32'hC0DE0008,32'h0, 1'b0,1'b0,32'h0,32'h0));
    vecs.push_back(mkVec(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h24,32'h0, 2'b10,2'b00,2'b00,32'h0,32'h0, 1'b1,1'b0,32'h24,32'h0));
    vecs.push_back(mkVec(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h24,32'h0, 2'b00,2'b00,2'b10,32'h0,32'hC0DE0009, 1'b0,1'b0,32'h0,32'h0));
    vecs.push_back(mkVec(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h24,32'h0, 2'b01,2'b00,2'b00,32'h0,32'h0, 1'b1,1'b0,32'h20,32'h0));
    vecs.push_back(mkVec(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h24,32'h0, 2'b00,2'b00,2'b01,32'hC0DE0008,32'h0, 1'b0,1'b0,32'h0,32'h0));
    // r0 write 0x10, then r1 reads it back
    vecs.push_back(mkVec(1'b1,1'b1,32'h10,32'hDEADBEEF, 1'b0,1'b0,32'h0,32'h0, 2'b01,2'b00,2'b00,32'h0,32'h0, 1'b0,1'b1,32'h10,32'hDEADBEEF));
    vecs.push_back(mkVec(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h10,32'h0, 2'b10,2'b00,2'b00,32'h0,32'h0, 1'b1,1'b0,32'h10,32'h0));
    vecs.push_back(mkVec(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b00,2'b00,2'b10,32'h0,32'hDEADBEEF, 1'b0,1'b0,32'h0,32'h0));
    // Misaligned requests: error grants, r0 first since r1 was granted last
    vecs.push_back(mkVec(1'b1,1'b1,32'h3FE,32'h55, 1'b1,1'b0,32'h13,32'h0, 2'b01,2'b01,2'b00,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0));
    vecs.push_back(mkVec(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'h13,32'h0, 2'b10,2'b10,2'b00,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0));
    // Last legal word
    vecs.push_back(mkVec(1'b1,1'b0,32'h3FC,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b01,2'b00,2'b00,32'h0,32'h0, 1'b1,1'b0,32'h3FC,32'h0));
    // r1 requests during RDATA then drops before being granted
    vecs.push_back(mkVec(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h40,32'h12345678, 2'b00,2'b00,2'b01,32'hC0DE00FF,32'h0, 1'b0,1'b0,32'h0,32'h0));
    vecs.push_back(mkVec(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b00,2'b00,2'b00,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0));
    // Aligned but one word past the end
    vecs.push_back(mkVec(1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h400,32'hAA, 2'b10,2'b10,2'b00,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0));
    // Four back-to-back r0 writes
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mkVec(1'b1,1'b1,32'h100 + 32'(4*i),32'(i+1), 1'b0,1'b0,32'h0,32'h0,
                           2'b01,2'b00,2'b00,32'h0,32'h0, 1'b0,1'b1,32'h100 + 32'(4*i),32'(i+1)));
    end
    vecs.push_back(mkVec(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b00,2'b00,2'b00,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0));

    @(negedge clock);
    #1 checkOutput("inReset", mkVec(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h24,32'h0,
                                      2'b00,2'b00,2'b00,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset_n = 1'b1;
      applyStimulus(vecs[i]);
      #1 checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    checkWord("mem0x10",  memModel[4],   32'hDEADBEEF);
    checkWord("mem0x3FC", memModel[255], 32'hC0DE00FF);
    checkWord("mem0x40",  memModel[16],  32'hC0DE0010);
    checkWord("mem0x100", memModel[64],  32'h1);
    checkWord("mem0x10C", memModel[67],  32'h4);

    // Reset pulsed while a read is outstanding
    @(negedge clock);
    v = mkVec(1'b1,1'b0,32'h3FC,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b01,2'b00,2'b00,32'h0,32'h0, 1'b1,1'b0,32'h3FC,32'h0);
    applyStimulus(v);
    #1 checkOutput("rdBeforeReset", v);
    @(negedge clock);
    reset_n = 1'b0;
    v = mkVec(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h24,32'h0, 2'b00,2'b00,2'b00,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0);
    applyStimulus(v);
    #1 checkOutput("resetInRdata", v);
    @(negedge clock);
    #1 checkOutput("resetHeld", v);
    @(negedge clock);
    reset_n = 1'b1;
    v = mkVec(1'b1,1'b0,32'h20,32'h0, 1'b1,1'b0,32'h24,32'h0, 2'b01,2'b00,2'b00,32'h0,32'h0, 1'b1,1'b0,32'h20,32'h0);
    #1 checkOutput("postResetGntR0", v);
    @(negedge clock);
    v = mkVec(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b00,2'b00,2'b01,32'hC0DE0008,32'h0, 1'b0,1'b0,32'h0,32'h0);
    applyStimulus(v);
    #1 checkOutput("postResetRvalid", v);
    @(negedge clock);
    v = mkVec(1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 2'b00,2'b00,2'b00,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0);
    #1 checkOutput("finalIdle", v);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
